// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: conversion handshake; master drives start/bcd, slave returns bin/busy/done/err
interface bcd2bin_seq_if #(parameter int NDIG = 2, parameter int BW = 7);
  logic start;
  logic [4*NDIG-1:0] bcd;
  logic [BW-1:0] bin;
  logic busy;
  logic done;
  logic err;
  modport master (output start, bcd, input bin, busy, done, err);
  modport slave (input start, bcd, output bin, busy, done, err);
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential reverse double-dabble BCD->binary; ports clk, rstn (sync active-low), io (start/bcd in, bin/busy/done/err out)
module bcd2bin_seq #(
  parameter int NDIG = 2,
  parameter int BW = 7
) (
  input logic clk,
  input logic rstn,
  bcd2bin_seq_if.slave io
);
  localparam int WW = 4*NDIG + BW;
  localparam int CW = $clog2(BW + 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t st;
  logic [WW-1:0] w, nxt;
  logic [CW-1:0] cnt;
  logic valid;
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < NDIG; i++)
      if (io.bcd[4*i +: 4] > 4'd9) valid = 1'b0;
  end
  always_comb begin
    nxt = w >> 1;
    for (int i = 0; i < NDIG; i++)
      if (nxt[BW+4*i +: 4] >= 4'd8) nxt[BW+4*i +: 4] = nxt[BW+4*i +: 4] - 4'd3;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st <= IDLE;
      w <= '0;
      cnt <= '0;
      io.bin <= '0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.err <= 1'b0;
    end else begin
      io.done <= 1'b0;
      io.err <= 1'b0;
      if (st == IDLE) begin
        if (io.start && valid) begin
          w <= {io.bcd, {BW{1'b0}}};
          cnt <= '0;
          st <= CONV;
          io.busy <= 1'b1;
        end else if (io.start) begin
          io.done <= 1'b1;
          io.err <= 1'b1;
        end
      end else begin
        w <= nxt;
        if (cnt == CW'(BW - 1)) begin
          io.bin <= nxt[BW-1:0];
          io.done <= 1'b1;
          io.busy <= 1'b0;
          st <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: randomized and directed checks of bcd2bin_seq against a decimal-arithmetic model
module tb_bcd2bin_seq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] last_bin = '0;
  bcd2bin_seq_if #(.NDIG(2), .BW(7)) io ();
  bcd2bin_seq #(.NDIG(2), .BW(7)) dut (.clk(clk), .rstn(rstn), .io(io));
  always #5 clk = ~clk;
  function automatic bit ref_valid(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction
  function automatic logic [6:0] ref_val(input logic [7:0] b);
    int v;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return v[6:0];
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_conv(input logic [7:0] b, output int busy_cnt, output int steps, output bit got_done, output bit got_err);
    io.bcd = b;
    io.start = 1'b1;
    step();
    io.start = 1'b0;
    busy_cnt = 0;
    steps = 1;
    got_done = 1'b0;
    got_err = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (io.busy) busy_cnt++;
      if (io.done) begin
        got_done = 1'b1;
        got_err = io.err;
      end else begin
        step();
        steps++;
      end
    end
  endtask
  task automatic check_conv(input string nm, input logic [7:0] b);
    int bc, st;
    bit d, e;
    run_conv(b, bc, st, d, e);
    n_cmp++;
    if (!d) begin
      n_bad++;
      $display("FAIL %s bcd=%h: done got 0 within bound, required 1", nm, b);
      return;
    end
    last_bin = ref_val(b);
    n_cmp++;
    if (io.bin !== last_bin) begin
      n_bad++;
      $display("FAIL %s bcd=%h: bin got %0d required %0d", nm, b, io.bin, last_bin);
    end
    n_cmp++;
    if (bc !== 7 || e !== 1'b0 || io.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s bcd=%h: busy_cycles=%0d err=%b busy=%b required 7/0/0", nm, b, bc, e, io.busy);
    end
  endtask
  task automatic check_idle_outputs(input string nm, input logic [6:0] eb);
    n_cmp++;
    if (io.bin !== eb || io.busy !== 1'b0 || io.done !== 1'b0 || io.err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: bin=%0d busy=%b done=%b err=%b required %0d/0/0/0", nm, io.bin, io.busy, io.done, io.err, eb);
    end
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    io.start = 1'b1;
    io.bcd = 8'h55;
    step();
    step();
    io.start = 1'b0;
    check_idle_outputs("reset", 7'd0);
    rstn = 1'b1;
    step();
    check_idle_outputs("after_reset", 7'd0);
    last_bin = '0;
  endtask
  task automatic test_directed();
    check_conv("zero", 8'h00);
    check_conv("d99", 8'h99);
    check_conv("d45", 8'h45);
    check_conv("d10", 8'h10);
  endtask
  task automatic test_invalid(input logic [7:0] b);
    io.bcd = b;
    io.start = 1'b1;
    step();
    io.start = 1'b0;
    n_cmp++;
    if (io.done !== 1'b1 || io.err !== 1'b1 || io.busy !== 1'b0 || io.bin !== last_bin) begin
      n_bad++;
      $display("FAIL invalid bcd=%h: done=%b err=%b busy=%b bin=%0d required 1/1/0/%0d", b, io.done, io.err, io.busy, io.bin, last_bin);
    end
    step();
    check_idle_outputs("invalid_after", last_bin);
  endtask
  task automatic test_back_to_back();
    bit seen;
    int st;
    io.bcd = 8'h12;
    io.start = 1'b1;
    step();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (io.done) seen = 1'b1;
      else begin
        io.bcd = 8'h77;
        io.start = 1'b1;
        step();
      end
    end
    n_cmp++;
    if (!seen || io.bin !== 7'd12 || io.err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b bin=%0d err=%b required 1/12/0", seen, io.bin, io.err);
    end
    io.bcd = 8'h34;
    io.start = 1'b1;
    step();
    io.start = 1'b0;
    io.bcd = 8'h00;
    st = 1;
    n_cmp++;
    if (io.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: busy got %b required 1", io.busy);
    end
    while (!io.done && st < 20) begin
      step();
      st++;
    end
    n_cmp++;
    if (st !== 8 || io.bin !== 7'd34 || io.err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: cycles=%0d bin=%0d err=%b required 8/34/0", st, io.bin, io.err);
    end
    last_bin = 7'd34;
  endtask
  task automatic test_reset_mid();
    bit any_done;
    io.bcd = 8'h67;
    io.start = 1'b1;
    step();
    io.start = 1'b0;
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check_idle_outputs("reset_mid", 7'd0);
    last_bin = '0;
    any_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (io.done || io.busy) any_done = 1'b1;
      step();
    end
    n_cmp++;
    if (any_done) begin
      n_bad++;
      $display("FAIL reset_abandon: done/busy got 1 after reset required 0");
    end
    check_conv("after_reset_58", 8'h58);
  endtask
  task automatic test_sweep();
    logic [7:0] b;
    for (int h = 0; h < 10; h++)
      for (int l = 0; l < 10; l++) begin
        b = {4'(h), 4'(l)};
        check_conv("sweep", b);
      end
  endtask
  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 60; k++) begin
      b = 8'($urandom);
      if (ref_valid(b)) check_conv("random", b);
      else test_invalid(b);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask
  initial begin
    io.start = 1'b0;
    io.bcd = '0;
    test_reset();
    test_directed();
    test_invalid(8'hA3);
    test_invalid(8'h3F);
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have parameter NDIG, default 2: number of packed BCD input digits.
REQ-002 The block SHALL have parameter BW, default 7: output binary width. BW SHALL satisfy 2^BW >= 10^NDIG.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled on a clk edge.
REQ-006 The block SHALL have port bcd, input, 4*NDIG bits: packed BCD operand, most significant digit in the top nibble.
REQ-007 The block SHALL have port bin, output, BW bits: binary natural result, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed request.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, flagging an invalid operand.

Function
REQ-011 The FSM SHALL have exactly two states:
- IDLE
- CONV
REQ-012 In IDLE with start=1 and every digit <= 9, the block SHALL, at that edge:
- load a working register with {bcd, BW zero bits};
- clear the iteration counter;
- enter CONV.
REQ-013 In IDLE with start=1 and any digit > 9, the block SHALL, at that edge:
- stay in IDLE;
- set done=1 and err=1 for the following cycle;
- leave bin unchanged.
REQ-014 Each CONV cycle SHALL perform one reverse double-dabble iteration:
- shift the working register right by 1;
- then subtract 3 from each BCD digit field whose value is >= 8.
REQ-015 After exactly BW iterations, the block SHALL, at that edge:
- copy the low BW bits of the working register to bin;
- set done=1 and err=0 for one cycle;
- return to IDLE.
REQ-016 Latency SHALL be fixed:
- start sampled at edge k;
- busy=1 during the cycles after edges k .. k+BW-1;
- done=1 during the cycle after edge k+BW.
REQ-017 busy SHALL be 1 exactly when the state is CONV.
REQ-018 start SHALL be ignored while in CONV; bcd SHALL be sampled only at the accepting edge.
REQ-019 A start while done=1 SHALL be accepted, because the state is then IDLE, giving back-to-back conversions with no idle gap.
REQ-020 bin SHALL hold its last valid result until the next successful completion.
REQ-021 done and err SHALL be 0 in every cycle except the pulses defined in REQ-013 and REQ-015.

Reset
REQ-022 When rstn=0 at a clk edge, the block SHALL force, regardless of state or start:
- state = IDLE;
- bin = 0, busy = 0, done = 0, err = 0;
- working register and counter = 0.
REQ-023 A reset during CONV SHALL abandon the conversion with no done pulse.
REQ-024 The first start after rstn returns to 1 SHALL be honoured normally.

Verification
REQ-025 The bench SHALL cover these directed scenarios at NDIG=2, BW=7:
- bcd=0x00, start pulse -> done after 7 busy cycles, bin=0, err=0.
- bcd=0x99 -> bin=99 (0x63); bcd=0x45 -> bin=45 (0x2D); bcd=0x10 -> bin=10.
- bcd=0xA3, start -> next cycle done=1, err=1, busy never 1, bin keeps the prior value.
- bcd=0x12 accepted, then start pulses with bcd=0x77 during busy -> ignored; bin=12. A start on the done cycle with bcd=0x34 -> bin=34 exactly 8 cycles later.
- rstn=0 at the 3rd CONV cycle -> next cycle all outputs 0, no done pulse; a new start with bcd=0x58 -> bin=58.
- Exhaustive sweep of all 100 valid operands 0x00..0x99 -> bin equals the decimal value each time, with a 7-cycle busy window.
